cl_sde_res_pack: RTL

CL_SDE_RES_PACK -- requirements
Module: cl_sde_res_pack

---
 rtl/cl_sde_pkg.sv | 24 ++
 rtl/cl_sde_keep_gen.sv | 21 ++
 rtl/cl_sde_res_pack.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cl_sde_pkg.sv
// ---------------------------------------------------------------------------
// cl_sde_pkg
// Shared constants and types for the SDE result packer.
//   WORD_W         : width of one narrow result word (4 x 16-bit outputs)
//   BEAT_W         : width of one packed output beat
//   WORDS_PER_BEAT : narrow words packed into one beat
//   KEEP_W         : byte-enable width of one beat
//   sde_state_e    : packer FSM states
// ---------------------------------------------------------------------------
package cl_sde_pkg;

  localparam int WORD_W         = 64;
  localparam int BEAT_W         = 512;
  localparam int WORDS_PER_BEAT = 8;
  localparam int KEEP_W         = BEAT_W / 8;

  // ST_FILL       : normal packing of incoming words
  // ST_FLUSH_PEND : a flushed partial beat waits for the output register
  typedef enum logic {
    ST_FILL       = 1'b0,
    ST_FLUSH_PEND = 1'b1
  } sde_state_e;

endpackage

// File: rtl/cl_sde_keep_gen.sv
// ---------------------------------------------------------------------------
// cl_sde_keep_gen
// Combinational tkeep generator for one output beat.
//   i_wr_idx : number of valid words in the beat, modulo 8
//              (0 means a full beat, 1..7 a partial beat)
//   o_keep   : byte enables; the low 8*i_wr_idx bytes set for a partial
//              beat, all bytes set for a full beat
// ---------------------------------------------------------------------------
module cl_sde_keep_gen
  import cl_sde_pkg::*;
(
  input  logic [2:0]        i_wr_idx,
  output logic [KEEP_W-1:0] o_keep
);

  // Each word slot owns 8 consecutive byte-enable bits.
  for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_slot
    assign o_keep[8*gi +: 8] = ((i_wr_idx == 3'd0) || (3'(gi) < i_wr_idx)) ? 8'hFF : 8'h00;
  end

endmodule

// File: rtl/cl_sde_res_pack.sv
// ---------------------------------------------------------------------------
// cl_sde_res_pack
// Packs 64-bit network result words into 512-bit AXI-stream beats (8 words
// per beat, word k in bits [64k+63:64k]). ots_last marks the beat holding the
// final word of an image; flush closes the current packet early with a
// partial beat.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_data      : narrow result word input
//   in_ready              : word accepted when in_valid & in_ready
//   flush                 : single-cycle early-close request
//   ots_valid/ots_ready   : output beat handshake
//   ots_data/keep/user    : beat payload, byte enables, user (always 0)
//   ots_last              : end of packet
//   pkt_cnt               : completed packet counter (wraps)
// ---------------------------------------------------------------------------
module cl_sde_res_pack
  import cl_sde_pkg::*;
#(
  parameter int IMG_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              ots_valid,
  input  logic              ots_ready,
  output logic [BEAT_W-1:0] ots_data,
  output logic [KEEP_W-1:0] ots_keep,
  output logic [63:0]       ots_user,
  output logic              ots_last,
  output logic [31:0]       pkt_cnt
);

  localparam logic [16:0] LAST_WCNT = 17'(IMG_WORDS - 1);

  sde_state_e        r_state;
  sde_state_e        w_state_next;
  logic [2:0]        r_wr_idx;
  logic [16:0]       r_img_wcnt;
  logic [BEAT_W-1:0] r_acc;
  logic              r_ots_valid;
  logic [BEAT_W-1:0] r_ots_data;
  logic [KEEP_W-1:0] r_ots_keep;
  logic              r_ots_last;
  logic [31:0]       r_pkt_cnt;

  logic              w_out_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_completes;
  logic [2:0]        w_eff_idx;
  logic [BEAT_W-1:0] w_beat_raw;
  logic [BEAT_W-1:0] w_beat_masked;
  logic [KEEP_W-1:0] w_keep;
  logic              w_load;
  logic              w_load_last;
  logic              w_clear_pkt;

  // Output register can take a new beat when empty or draining this cycle.
  assign w_out_free  = !r_ots_valid || ots_ready;

  // Only the completing 8th word needs a free output register; earlier words
  // go into the accumulator. FLUSH_PEND freezes input so the partial beat
  // content cannot change while it waits.
  assign w_in_ready  = rst_n &&
                       !(((r_wr_idx == 3'd7) && r_ots_valid && !ots_ready) ||
                         (r_state == ST_FLUSH_PEND));
  assign w_accept    = in_valid && w_in_ready;
  assign w_completes = w_accept && (r_wr_idx == 3'd7);

  // Word count of the beat including any same-cycle word (wraps 8 -> 0).
  assign w_eff_idx   = r_wr_idx + {2'b00, w_accept};

  // Beat content as seen this cycle: accumulator with the incoming word
  // dropped into its slot, so a beat can be loaded without waiting a cycle.
  for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_raw
    assign w_beat_raw[WORD_W*gi +: WORD_W] =
      (w_accept && (r_wr_idx == 3'(gi))) ? in_data : r_acc[WORD_W*gi +: WORD_W];
  end

  cl_sde_keep_gen u_keep_gen (
    .i_wr_idx (w_eff_idx),
    .o_keep   (w_keep)
  );

  // Stale accumulator slots beyond the valid words are zeroed on the way out.
  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_mask
    assign w_beat_masked[8*gi +: 8] = w_keep[gi] ? w_beat_raw[8*gi +: 8] : 8'h00;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and beat-load decisions
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_last  = 1'b0;
    w_clear_pkt  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_completes) begin
          // in_ready already guarantees the output register is free here.
          w_load      = 1'b1;
          w_load_last = flush || (r_img_wcnt == LAST_WCNT);
          w_clear_pkt = flush;
        end else if (flush && (w_eff_idx != 3'd0)) begin
          if (w_out_free) begin
            w_load      = 1'b1;
            w_load_last = 1'b1;
            w_clear_pkt = 1'b1;
          end else begin
            w_state_next = ST_FLUSH_PEND;
          end
        end
      end
      ST_FLUSH_PEND: begin
        // Flush pulses are ignored here; the partial beat is already queued.
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_last  = 1'b1;
          w_clear_pkt  = 1'b1;
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  // Word accumulator; contents need no reset because unused slots are masked.
  for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_acc
    always_ff @(posedge clk) begin
      if (w_accept && (r_wr_idx == 3'(gi))) begin
        r_acc[WORD_W*gi +: WORD_W] <= in_data;
      end
    end
  end

  // Counters, output register and packet counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_idx    <= 3'd0;
      r_img_wcnt  <= 17'd0;
      r_ots_valid <= 1'b0;
      r_ots_data  <= '0;
      r_ots_keep  <= '0;
      r_ots_last  <= 1'b0;
      r_pkt_cnt   <= 32'd0;
    end else begin
      if (w_clear_pkt) begin
        r_wr_idx   <= 3'd0;
        r_img_wcnt <= 17'd0;
      end else if (w_accept) begin
        r_wr_idx   <= r_wr_idx + 3'd1;
        r_img_wcnt <= (r_img_wcnt == LAST_WCNT) ? 17'd0 : r_img_wcnt + 17'd1;
      end

      if (w_load) begin
        r_ots_valid <= 1'b1;
        r_ots_data  <= w_beat_masked;
        r_ots_keep  <= w_keep;
        r_ots_last  <= w_load_last;
      end else if (ots_ready) begin
        r_ots_valid <= 1'b0;
      end

      if (r_ots_valid && ots_ready && r_ots_last) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign ots_valid = r_ots_valid;
  assign ots_data  = r_ots_data;
  assign ots_keep  = r_ots_keep;
  assign ots_last  = r_ots_last;
  assign ots_user  = '0;
  assign pkt_cnt   = r_pkt_cnt;

endmodule
